// File: rtl/tabela_verdade_ctrl.sv
// Truth-table sweep sequencer: walks every input combination on vars_o and builds per-function
// minterm masks/counts. Optional EQUIV_CHECK_EN adds a registered mask-equality comparator.

module tvc_lane #(
  parameter int N_VARS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     cap,
  input  logic [N_VARS-1:0]        idx,
  input  logic                     f,
  output logic [(1<<N_VARS)-1:0]   mask,
  output logic [N_VARS:0]          count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask  <= '0;
      count <= '0;
    end else if (clr) begin
      mask  <= '0;
      count <= '0;
    end else if (cap) begin
      mask[idx] <= f;
      count     <= count + {{N_VARS{1'b0}}, f};
    end
  end
endmodule

module tabela_verdade_ctrl #(
  parameter int N_VARS  = 4,
  parameter int N_FUNCS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic [N_VARS-1:0]        vars_o,
  input  logic [N_FUNCS-1:0]       f_i,
  output logic                     busy,
  output logic                     done,
  output logic                     valid,
  input  logic [2:0]               rd_sel,
  output logic [(1<<N_VARS)-1:0]   rd_mask,
  output logic [N_VARS:0]          rd_count
`ifdef EQUIV_CHECK_EN
  ,
  input  logic [2:0]               cmp_a,
  input  logic [2:0]               cmp_b,
  output logic                     equiv
`endif
);
  localparam int N_COMB = 1 << N_VARS;
  localparam logic [N_VARS-1:0] LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t                              state;
  logic [N_VARS-1:0]                   idx;
  logic                                clr, cap;
  logic [N_FUNCS-1:0][N_COMB-1:0]      masks;
  logic [N_FUNCS-1:0][N_VARS:0]        counts;

  // abort beats both a new start and the capture of the current combination
  assign clr    = (state != S_SWEEP) && start && !abort;
  assign cap    = (state == S_SWEEP) && !abort;
  assign vars_o = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: if (start && !abort) begin
          state <= S_SWEEP;
          idx   <= '0;
          busy  <= 1'b1;
          valid <= 1'b0;
        end
        S_SWEEP: begin
          if (abort) begin
            state <= S_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
          end else if (idx == LAST) begin
            state <= S_DONE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_FUNCS; k++) begin : g_lane
    tvc_lane #(.N_VARS(N_VARS)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .cap   (cap),
      .idx   (idx),
      .f     (f_i[k]),
      .mask  (masks[k]),
      .count (counts[k])
    );
  end

  always_comb begin
    rd_mask  = '0;
    rd_count = '0;
    for (int k = 0; k < N_FUNCS; k++) begin
      if (rd_sel == 3'(k)) begin
        rd_mask  = masks[k];
        rd_count = counts[k];
      end
    end
  end

`ifdef EQUIV_CHECK_EN
  logic [N_COMB-1:0] mask_a, mask_b;
  logic              ok_a, ok_b;

  always_comb begin
    mask_a = '0;
    mask_b = '0;
    ok_a   = 1'b0;
    ok_b   = 1'b0;
    for (int k = 0; k < N_FUNCS; k++) begin
      if (cmp_a == 3'(k)) begin
        mask_a = masks[k];
        ok_a   = 1'b1;
      end
      if (cmp_b == 3'(k)) begin
        mask_b = masks[k];
        ok_b   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) equiv <= 1'b0;
    else        equiv <= valid && ok_a && ok_b && (mask_a == mask_b);
  end
`endif
endmodule
